// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch sequencer types and constants
package cpu_pkg;
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_DROP} fetch_state_t;

  localparam int          INST_BYTES   = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - one-entry instruction buffer with valid/ready and flush
module fetch_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        flush,
  input  logic        ready,
  output logic [31:0] data,
  output logic        valid,
  output logic        free
);
  logic [31:0] data_d, data_q;
  logic        valid_d, valid_q;

  // Flush wins over a same-cycle ready, so a redirect never counts as a transfer.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign free  = !valid_q || ready;
endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction fetch sequencer driving an external dffe32 PC.
// Optional FETCH_ALIGN_CHK_EN: force word-aligned branch targets and flag misalignment.
module fetch_seq
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic        pc_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        misalign
);
  fetch_state_t state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  tgt;
  logic [31:0]  buf_data;
  logic         buf_load, buf_valid, buf_free;
  logic         redirect;

  assign redirect = !clr && br_taken && (state_q != S_BOOT);

`ifdef FETCH_ALIGN_CHK_EN
  logic mis_d, mis_q;

  assign tgt = {br_target[31:2], 2'b00};

  always_comb begin
    mis_d = mis_q;
    if (redirect && (br_target[1:0] != 2'b00)) mis_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end

  assign misalign = mis_q && !clr;
`else
  assign tgt      = br_target;
  assign misalign = 1'b0;
`endif

  // Redirect leaves a fetch outstanding only if no ack lands in the same cycle.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pc_d     = '0;
    pc_e     = 1'b0;
    imem_req = 1'b0;
    buf_load = 1'b0;
    if (redirect) begin
      pc_d    = tgt;
      pc_e    = 1'b1;
      state_d = (state_q == S_FETCH || imem_ack) ? S_FETCH : S_DROP;
    end else if (!clr) begin
      case (state_q)
        S_BOOT: begin
          pc_d    = RESET_PC;
          pc_e    = 1'b1;
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (!stall && buf_free) begin
            imem_req = 1'b1;
            addr_d   = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            buf_load = 1'b1;
            pc_d     = pc_q + 32'(INST_BYTES);
            pc_e     = 1'b1;
            state_d  = S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_ack) state_d = S_FETCH;
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_BOOT;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  fetch_buf u_buf (
    .clk       (clk),
    .clr       (clr),
    .load      (buf_load),
    .load_data (imem_rdata),
    .flush     (redirect),
    .ready     (inst_ready),
    .data      (buf_data),
    .valid     (buf_valid),
    .free      (buf_free)
  );

  assign imem_addr  = clr ? '0 : addr_q;
  assign inst       = clr ? '0 : buf_data;
  assign inst_valid = buf_valid && !clr;
endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction fetch sequencer for the 32-bit CPU. Drives the `d`/`e` side of the external `dffe32` program-counter register and reads its `q` back. Issues split-transaction reads to instruction memory and presents one buffered instruction to decode through a valid/ready handshake. Handles boot load, stalls and taken-branch redirect, including discarding in-flight fetches.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded in the boot cycle.
- `clk  in  1`: clock; all state updates on the rising edge.
- `clr  in  1`: reset, synchronous, active-high.
- `stall  in  1`: inhibits issuing new fetches.
- `br_taken  in  1`: single-cycle redirect strobe.
- `br_target  in  32`: redirect address, valid with `br_taken`.
- `pc_q  in  32`: current PC from the external `dffe32`.
- `pc_d  out  32`: next PC to the `dffe32` `d` input.
- `pc_e  out  1`: `dffe32` enable.
- `imem_req  out  1`: one-cycle read request pulse.
- `imem_addr  out  32`: read address, registered at issue, held until the next issue.
- `imem_ack  in  1`: one-cycle response strobe.
- `imem_rdata  in  32`: response data, valid with `imem_ack`.
- `inst  out  32`: buffered instruction.
- `inst_valid  out  1`: buffer full.
- `inst_ready  in  1`: decode accepts; transfer when `inst_valid & inst_ready`.
- `misalign  out  1`: sticky misaligned-target flag (see Configuration).

## Operation
- States:
  - BOOT: entered from `clr`.
  - FETCH: may issue a fetch.
  - WAIT: one fetch outstanding.
  - DROP: outstanding fetch is to be discarded.
- While `clr` is high, all outputs are 0: `imem_req`, `imem_addr`, `pc_d`, `pc_e`, `inst`, `inst_valid`, `misalign`. State returns to BOOT.
- BOOT, first cycle after `clr` falls: `pc_d=RESET_PC`, `pc_e=1`, then go to FETCH. `br_taken` is ignored in BOOT.
- FETCH: issue when `!stall` and the buffer is free (`!inst_valid` or `inst_ready` this cycle).
  - On issue: `imem_req=1` for that cycle, `imem_addr<=pc_q`, go to WAIT.
  - Otherwise stay in FETCH with `imem_req=0`.
- WAIT on `imem_ack`:
  - `inst<=imem_rdata`, `inst_valid<=1`.
  - `pc_d=pc_q+32'd4` (modulo 2^32; `32'hFFFF_FFFC` wraps to 0), `pc_e=1`.
  - Go to FETCH.
- `stall` never cancels an outstanding fetch.
- Redirect (`br_taken=1` in FETCH, WAIT or DROP):
  - `pc_d=br_target`, `pc_e=1`.
  - Clear `inst_valid`, even if `inst_ready` is high that cycle; no transfer occurs.
  - No issue that cycle.
  - Next state: FETCH if no fetch is outstanding after this edge, otherwise DROP.
- Redirect coinciding with `imem_ack` in WAIT: the ack data is dropped, the target is loaded, and the next state is FETCH.
- DROP: on `imem_ack`, discard the data, keep `pc_e=0`, go to FETCH. A further `br_taken` in DROP reloads the PC and the state stays DROP.
- Priority: `clr` > `br_taken` > `imem_ack` > `stall`.
- `pc_e=0` in every cycle not listed above.

## Timing
- `pc_d`/`pc_e`/`imem_req` are combinational from state and inputs. `imem_addr`, `inst`, `inst_valid`, `misalign` are registered.
- The memory responds no earlier than the cycle after `imem_req`. At most one fetch is outstanding.
- Minimum fetch latency: issue at cycle t, ack at t+1, `inst_valid` high at t+2. Peak throughput is one instruction per 2 cycles.
- `pc_q` reflects a `pc_e` write one edge later. The block never issues in the cycle `pc_e` is high.
- `inst` and `inst_valid` are stable while `inst_valid & !inst_ready`, except on redirect.

## Configuration
- `FETCH_ALIGN_CHK_EN` defined:
  - A `br_taken` with `br_target[1:0]!=0` sets `misalign` (sticky until `clr`).
  - The loaded PC becomes `{br_target[31:2],2'b00}`.
- Undefined: `br_target` is loaded unmodified and `misalign` is tied to 0. The port is present in both builds.

## Structure
- Shared package `cpu_pkg`:
  - State encoding typedef `fetch_state_t` (BOOT, FETCH, WAIT, DROP).
  - `INST_BYTES=4`.
  - `RESET_PC` default constant.
- One natural sub-module: `fetch_buf`, the one-entry instruction buffer with valid/ready and flush.

## Test plan
- Boot: `clr` high 2 cycles, then low; `RESET_PC=32'h0000_0100` -> `pc_e=1`, `pc_d=32'h100` in the first cycle; `imem_req` with `imem_addr=32'h100` one cycle later.
- Sequential fetch: ack one cycle after each req with data `32'hA0`, `32'hA1`, `inst_ready=1` -> `inst` sequence `A0`, `A1`; PC goes `0x100`, `0x104`, `0x108`; one instruction every 2 cycles.
- Backpressure and stall: `inst_ready=0` with the buffer full -> no `imem_req`, `inst` held. `stall=1` in FETCH -> no req; releasing it issues on the next cycle.
- Redirect in WAIT: `br_taken`, `br_target=32'h200` before ack; the ack arrives 2 cycles later with `32'hDEAD` -> `DEAD` is never valid, next `imem_addr=32'h200`.
- Redirect coincident with ack and a full buffer -> `inst_valid` cleared, ack data dropped, next state FETCH, `pc_d=32'h200`.
- Wrap and alignment: PC `32'hFFFF_FFFC` fetch -> next PC `0`. With `FETCH_ALIGN_CHK_EN`, target `32'h203` -> `pc_d=32'h200` and `misalign=1` until `clr`.
